// File: rtl/mem_responder.sv
// Memory-side responder: turns each 3-cycle enable burst into one BRAM / I/O / unmapped access.
// Optional sticky protocol checker on err_o, built only when MEM_PROTOCOL_CHECK_EN is defined.
module mem_responder #(
  parameter int          BRAM_AW = 10,
  parameter logic [15:0] IO_ADDR = 16'hFFFF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               mem_mem_ena,
  input  logic               mem_wr_ena,
  input  logic [15:0]        mem_addr,
  input  logic [15:0]        mem_wdata,
  output logic [15:0]        mem_rdata,
  output logic               mem_ready,
  input  logic [15:0]        sw_i,
  output logic [15:0]        hex_o,
  output logic               bram_en,
  output logic               bram_we,
  output logic [BRAM_AW-1:0] bram_addr,
  output logic [15:0]        bram_din,
  input  logic [15:0]        bram_dout,
  output logic               err_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] T2   = 2'd1;
  localparam logic [1:0] T3   = 2'd2;

  localparam logic [1:0] SRC_NONE = 2'd0;
  localparam logic [1:0] SRC_BRAM = 2'd1;
  localparam logic [1:0] SRC_IO   = 2'd2;

  localparam logic [16:0] BRAM_WORDS = 17'd1 << BRAM_AW;

  logic [1:0]  state;
  logic        t1;
  logic        is_io;
  logic        in_range;
  logic        wr_p1;
  logic [1:0]  src_p1;
  logic [15:0] sw_sync_p0;
  logic [15:0] sw_sync_p1;
  logic [15:0] sw_p1;
  logic [15:0] sw_p2;

  assign is_io    = (mem_addr == IO_ADDR);
  assign in_range = ({1'b0, mem_addr} < BRAM_WORDS) && !is_io;
  assign t1       = (state == IDLE) && mem_mem_ena;

  assign bram_en   = !reset && mem_mem_ena && in_range;
  assign bram_we   = !reset && t1 && mem_wr_ena && in_range;
  assign bram_addr = mem_addr[BRAM_AW-1:0];
  assign bram_din  = mem_wdata;
  assign mem_ready = !reset && (state == T3);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    state <= mem_mem_ena ? T2 : IDLE;
        T2:      state <= mem_mem_ena ? T3 : IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // T1 boundary: latch operation type, read source, I/O write and switch snapshot
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_p1  <= 1'b0;
      src_p1 <= SRC_NONE;
      hex_o  <= 16'h0000;
      sw_p1  <= 16'h0000;
    end else if (t1) begin
      wr_p1  <= mem_wr_ena;
      src_p1 <= in_range ? SRC_BRAM : (is_io ? SRC_IO : SRC_NONE);
      sw_p1  <= sw_sync_p1;
      if (mem_wr_ena && is_io) hex_o <= mem_wdata;
    end
  end

  // Switch synchronizer runs freely; T2 boundary stages the snapshot to line up with BRAM latency
  always_ff @(posedge clk) begin
    if (reset) begin
      sw_sync_p0 <= 16'h0000;
      sw_sync_p1 <= 16'h0000;
      sw_p2      <= 16'h0000;
    end else begin
      sw_sync_p0 <= sw_i;
      sw_sync_p1 <= sw_sync_p0;
      if (state == T2) sw_p2 <= sw_p1;
    end
  end

  always_comb begin
    mem_rdata = 16'h0000;
    if (mem_ready && !wr_p1) begin
      case (src_p1)
        SRC_BRAM: mem_rdata = bram_dout;
        SRC_IO:   mem_rdata = sw_p2;
        default:  mem_rdata = 16'h0000;
      endcase
    end
  end

`ifdef MEM_PROTOCOL_CHECK_EN
  logic [15:0] addr_p1;
  logic        err;

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_p1 <= 16'h0000;
      err     <= 1'b0;
    end else begin
      if (t1) addr_p1 <= mem_addr;
      if ((state == T2) && !mem_mem_ena) err <= 1'b1;
      if (((state == T2) || (state == T3)) &&
          ((mem_addr != addr_p1) || (mem_wr_ena != wr_p1))) err <= 1'b1;
    end
  end

  assign err_o = err;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the SLC-3 datapath. It sits between the control/datapath memory port and the on-chip BRAM plus the memory-mapped I/O. It answers each three-cycle enable burst issued by the control unit with exactly one memory operation and returns read data in the third cycle. It also owns the hex-display output register and the switch input.

## Interface
- BRAM_AW, 10, BRAM word-address width; BRAM holds 2^BRAM_AW 16-bit words starting at 0x0000.
- IO_ADDR, 16'hFFFF, address of the I/O register: writes go to the hex display, reads return the switches.
- clk  in  1  system clock; one clock domain. Reset is synchronous and active-high.
- reset  in  1  synchronous active-high reset.
- mem_mem_ena  in  1  memory operation enable from control; held for 3 consecutive cycles per transaction.
- mem_wr_ena  in  1  write enable; must be constant across the transaction.
- mem_addr  in  16  word address (MAR); must be constant across the transaction.
- mem_wdata  in  16  write data (MDR).
- mem_rdata  out  16  read data; valid only in cycle T3 of a read, otherwise 0x0000.
- mem_ready  out  1  one-cycle pulse in T3 of every completed transaction, read or write.
- sw_i  in  16  board switches; asynchronous to clk.
- hex_o  out  16  hex-display register.
- bram_en  out  1  BRAM port enable.
- bram_we  out  1  BRAM write enable.
- bram_addr  out  BRAM_AW  BRAM address.
- bram_din  out  16  BRAM write data.
- bram_dout  in  16  BRAM read data; the BRAM is synchronous with an output register, so there are 2 cycles from address to data.
- err_o  out  1  sticky protocol error flag (see Configuration).

## Operation
- FSM states are IDLE, T2 and T3. The cycle in which IDLE sees mem_mem_ena=1 is T1.
- IDLE: if mem_mem_ena=1, go to T2; otherwise stay in IDLE.
- T2: if mem_mem_ena=1, go to T3. If mem_mem_ena=0, abort to IDLE: no ready pulse, and err_o sets when checking is enabled.
- T3: always go to IDLE. If mem_mem_ena is still high in the next cycle, a new transaction starts there (that cycle is its T1).
- Decode in T1:
  - in_range = (mem_addr < 2^BRAM_AW) and not I/O.
  - is_io = (mem_addr == IO_ADDR).
  - Any other address is unmapped: writes are dropped and reads return 0x0000.
- BRAM path:
  - bram_en = mem_mem_ena and in_range, in every cycle of the transaction.
  - bram_addr = mem_addr[BRAM_AW-1:0].
  - bram_din = mem_wdata.
  - bram_we = 1 only in T1 of an in-range write, so each transaction writes exactly once.
- I/O write: hex_o <= mem_wdata at the end of T1, once per transaction.
- I/O read:
  - sw_i passes through a 2-flop synchronizer that runs continuously.
  - The synchronized value is captured at the end of T1 and moved through a second register at the end of T2, so it matches BRAM latency.
- Read select: a source select (BRAM / IO / unmapped) is registered at the end of T1 and carried to T3.
- In T3 of a read, mem_rdata is:
  - bram_dout for in-range addresses;
  - the staged switch value for IO_ADDR;
  - 0x0000 for unmapped addresses.
- Values after reset:
  - state = IDLE; mem_rdata = 0x0000; mem_ready = 0.
  - hex_o = 0x0000; err_o = 0; bram_en = bram_we = 0.
  - Synchronizer and staging registers = 0.

## Timing
- Read latency: data is valid in T3, 2 clock edges after T1. The control unit's MDR captures it at the end of T3.
- Write commit: at the end of T1, for both BRAM and hex_o.
- A switch change is visible to an I/O read whose T1 begins at least 2 cycles after the change.
- Reset asserted mid-transaction: the state goes to IDLE on that edge and no ready pulse is produced. A BRAM write already committed in T1 is kept; hex_o clears.
- Ena held for 6 cycles: two back-to-back transactions, with mem_ready in cycles 3 and 6.
- mem_wr_ena is sampled only in T1; a change later in the transaction does not change the operation.

## Configuration
- MEM_PROTOCOL_CHECK_EN defined: err_o sets and stays set until reset when any of these occur:
  - mem_mem_ena drops in T2;
  - mem_addr changes between T1 and T3;
  - mem_wr_ena changes between T1 and T3.
- MEM_PROTOCOL_CHECK_EN undefined: err_o is tied to 0 and the checker logic is not built. All other behaviour is identical.

## Test plan
- Write 0x1234 to address 0x0005 (ena for 3 cycles, wr=1), then read it back. Expect bram_we high in T1 only, mem_rdata=0x1234 in T3 of the read, and mem_ready in T3 of both transactions.
- Write 0xBEEF to 0xFFFF. Expect hex_o=0xBEEF after T1 and bram_en=0 throughout. With sw_i=0x00A5 stable for 2 or more cycles, a read of 0xFFFF returns 0x00A5 in T3.
- Read 0x8000 with BRAM_AW=10. Expect mem_rdata=0x0000 in T3 with mem_ready=1. A write to 0x8000 leaves BRAM and hex_o unchanged.
- Hold ena for 6 cycles reading 0x0001 then 0x0002, with the address changed at cycle 4. Expect mem_ready in cycles 3 and 6 and the correct data in each T3.
- Assert reset in T2 of an I/O write to 0xFFFF with data 0x5555. Expect state=IDLE, hex_o=0x0000, no ready pulse, and a new transaction works normally afterwards.
- With MEM_PROTOCOL_CHECK_EN: drop ena in T2, then change mem_addr in T3 of a later transaction. Expect err_o=1 from the abort onward and no ready pulse for the aborted transaction. Without the macro, err_o stays 0.
